aer_rx_decoder: RTL and testbench

//  Receiving end of the row/column AER spike link. Synchronises the 4-phase request from the
//  row/column arbiter tree, captures the row/column address, returns the acknowledge, and

---
 rtl/aer_rx_decoder.sv | 144 ++++++++++++++
 tb/tb_aer_rx_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_rx_decoder.sv
// Receive side of the row/column AER link: synchronises the 4-phase request, captures the
// address after a settle delay, returns the acknowledge and buffers events in a show-ahead FIFO.
module aer_rx_decoder #(
  parameter int N_ROW   = 12,
  parameter int N_COL   = 12,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aer_req,
  input  logic [ADDR_W-1:0] aer_row,
  input  logic [ADDR_W-1:0] aer_col,
  output logic              aer_ack,
  input  logic              aer_dis,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [ADDR_W-1:0] ev_row,
  output logic [ADDR_W-1:0] ev_col,
  output logic [N_ROW-1:0]  ev_row_onehot,
  output logic [N_COL-1:0]  ev_col_onehot,
  output logic [15:0]       ev_count,
  output logic              addr_err,
  output logic              timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] ROW_LIM = (ADDR_W + 1)'(N_ROW);
  localparam logic [ADDR_W:0] COL_LIM = (ADDR_W + 1)'(N_COL);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACK, S_RELEASE} state_t;

  state_t              state;
  logic                req_meta;
  logic                req_s;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       tcnt;
  logic [2*ADDR_W-1:0] mem [DEPTH];
  logic [PW:0]         wptr;
  logic [PW:0]         rptr;
  logic                full;
  logic                empty;
  logic                in_range;
  logic                capture;
  logic                push;
  logic                pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign in_range = ({1'b0, aer_row} < ROW_LIM) && ({1'b0, aer_col} < COL_LIM);
  assign capture  = (state == S_SETTLE) && (cnt == CW'(SETTLE - 1));
  assign push     = capture && in_range;
  assign pop      = !empty && ev_ready;
  assign ev_valid = !empty;
  assign {ev_row, ev_col} = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= aer_req;
      req_s    <= req_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      aer_ack     <= 1'b0;
      ev_count    <= '0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        // Full FIFO withholds the handshake so the sender keeps req high (backpressure).
        S_IDLE: begin
          if (req_s && !aer_dis && !full) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
        end
        S_SETTLE: begin
          if (capture) begin
            aer_ack <= 1'b1;
            tcnt    <= '0;
            state   <= S_ACK;
            if (in_range) ev_count <= ev_count + 16'd1;
            else          addr_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          if (!req_s) begin
            aer_ack <= 1'b0;
            state   <= S_IDLE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            aer_ack     <= 1'b0;
            state       <= S_RELEASE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!req_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[PW-1:0]] <= {aer_row, aer_col};
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_comb begin
    ev_row_onehot = '0;
    ev_col_onehot = '0;
    if (ev_valid) begin
      for (int unsigned i = 0; i < N_ROW; i++)
        if (ev_row == ADDR_W'(i)) ev_row_onehot[i] = 1'b1;
      for (int unsigned j = 0; j < N_COL; j++)
        if (ev_col == ADDR_W'(j)) ev_col_onehot[j] = 1'b1;
    end
  end

endmodule

// File: tb/tb_aer_rx_decoder.sv
// Self-checking bench for aer_rx_decoder: directed handshake scenarios plus randomized event
// streams checked against an in-order queue model of accepted events.
module tb_aer_rx_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        aer_req;
  logic [3:0]  aer_row;
  logic [3:0]  aer_col;
  logic        aer_ack;
  logic        aer_dis;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_row;
  logic [3:0]  ev_col;
  logic [11:0] ev_row_onehot;
  logic [11:0] ev_col_onehot;
  logic [15:0] ev_count;
  logic        addr_err;
  logic        timeout_err;

  int compared   = 0;
  int mismatched = 0;
  int exp_count  = 0;
  bit sender_done;
  logic [3:0] q_row[$];
  logic [3:0] q_col[$];

  always #5 clk = ~clk;

  aer_rx_decoder #(
    .N_ROW(12), .N_COL(12), .ADDR_W(4), .DEPTH(4), .SETTLE(2), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .aer_req(aer_req), .aer_row(aer_row), .aer_col(aer_col),
    .aer_ack(aer_ack), .aer_dis(aer_dis), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_row(ev_row), .ev_col(ev_col), .ev_row_onehot(ev_row_onehot),
    .ev_col_onehot(ev_col_onehot), .ev_count(ev_count), .addr_err(addr_err),
    .timeout_err(timeout_err)
  );

  task automatic do_reset();
    rst = 1'b1; aer_req = 1'b0; aer_dis = 1'b0; ev_ready = 1'b0;
    aer_row = '0; aer_col = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_row.delete(); q_col.delete();
    exp_count = 0;
  endtask

  task automatic raise_req(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    aer_row = r; aer_col = c; aer_req = 1'b1;
    if (r < 12 && c < 12) begin
      q_row.push_back(r); q_col.push_back(c); exp_count++;
    end
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string name);
    int n = 0;
    while (aer_ack !== lvl && n < budget) begin @(negedge clk); n++; end
    compared++;
    if (aer_ack !== lvl) begin
      mismatched++;
      $display("FAIL %s: aer_ack=%b required %b within %0d cycles", name, aer_ack, lvl, budget);
    end
  endtask

  task automatic finish_handshake();
    wait_ack(1'b1, 400, "ack_rise");
    aer_req = 1'b0;
    wait_ack(1'b0, 10, "ack_fall");
  endtask

  task automatic send_event(input logic [3:0] r, input logic [3:0] c);
    raise_req(r, c);
    finish_handshake();
  endtask

  task automatic check_count(input string name);
    compared++;
    if (ev_count !== 16'(exp_count)) begin
      mismatched++;
      $display("FAIL %s: ev_count=%0d required %0d", name, ev_count, exp_count);
    end
  endtask

  // Consumer: random ev_ready, compares every popped head against the model queue.
  task automatic consume(input int ready_pct, input int budget);
    int n = 0;
    logic [11:0] er, ec;
    while (n < budget) begin
      @(negedge clk); n++;
      ev_ready = ($urandom_range(99) < ready_pct);
      if (ev_valid && ev_ready) begin
        compared++;
        if (q_row.size() == 0) begin
          mismatched++;
          $display("FAIL pop_unexpected: got row=%0d col=%0d required no event", ev_row, ev_col);
        end else begin
          er = 12'b1 << q_row[0];
          ec = 12'b1 << q_col[0];
          if (ev_row !== q_row[0] || ev_col !== q_col[0] ||
              ev_row_onehot !== er || ev_col_onehot !== ec) begin
            mismatched++;
            $display("FAIL pop_event: got row=%0d col=%0d oh=%h/%h required row=%0d col=%0d oh=%h/%h",
                     ev_row, ev_col, ev_row_onehot, ev_col_onehot, q_row[0], q_col[0], er, ec);
          end
          void'(q_row.pop_front()); void'(q_col.pop_front());
        end
      end
      if (sender_done && q_row.size() == 0 && !ev_valid) break;
    end
    compared++;
    if (!(sender_done && q_row.size() == 0)) begin
      mismatched++;
      $display("FAIL drain: %0d events left, sender_done=%0b, required 0 and 1", q_row.size(), sender_done);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (aer_ack !== 1'b0 || ev_valid !== 1'b0 || ev_row_onehot !== '0 || ev_col_onehot !== '0 ||
        ev_count !== '0 || addr_err !== 1'b0 || timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: ack=%b valid=%b oh=%h/%h cnt=%0d aerr=%b terr=%b required all 0",
               aer_ack, ev_valid, ev_row_onehot, ev_col_onehot, ev_count, addr_err, timeout_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    ev_ready = 1'b1;
    raise_req(4'd5, 4'd9);
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      compared++;
      if (aer_ack !== (e == 4)) begin
        mismatched++;
        $display("FAIL single_ack_latency: after edge E%0d ack=%b required %b", e, aer_ack, e == 4);
      end
    end
    compared++;
    if (ev_valid !== 1'b1 || ev_row_onehot !== 12'h020 || ev_col_onehot !== 12'h200) begin
      mismatched++;
      $display("FAIL single_onehot: valid=%b oh=%h/%h required 1 020/200", ev_valid, ev_row_onehot, ev_col_onehot);
    end
    check_count("single_count");
    @(negedge clk);
    compared++;
    if (ev_valid !== 1'b0 || ev_row_onehot !== '0 || ev_col_onehot !== '0) begin
      mismatched++;
      $display("FAIL single_pop: valid=%b oh=%h/%h required 0 000/000", ev_valid, ev_row_onehot, ev_col_onehot);
    end
    aer_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (aer_ack !== (k < 2)) begin
        mismatched++;
        $display("FAIL single_ack_release: %0d edges after req low ack=%b required %b", k + 1, aer_ack, k < 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int hi = 0;
    do_reset();
    for (int i = 0; i < 4; i++) send_event(4'($urandom_range(11)), 4'($urandom_range(11)));
    check_count("bp_four_buffered");
    raise_req(4'($urandom_range(11)), 4'($urandom_range(11)));
    repeat (30) begin @(negedge clk); if (aer_ack) hi++; end
    compared++;
    if (hi != 0) begin
      mismatched++;
      $display("FAIL bp_fifth_held: ack high %0d cycles while full, required 0", hi);
    end
    sender_done = 1'b0;
    fork
      begin finish_handshake(); sender_done = 1'b1; end
      consume(100, 500);
    join
    check_count("bp_five_total");
  endtask

  task automatic test_addr_err();
    do_reset();
    send_event(4'd12, 4'd3);
    repeat (3) @(negedge clk);
    compared++;
    if (ev_valid !== 1'b0 || addr_err !== 1'b1) begin
      mismatched++;
      $display("FAIL addr_err_row: valid=%b addr_err=%b required 0 1", ev_valid, addr_err);
    end
    check_count("addr_err_count");
    send_event(4'($urandom_range(11)), 4'($urandom_range(15, 12)));
    check_count("addr_err_col_count");
    sender_done = 1'b1;
    send_event(4'd0, 4'd11);
    consume(100, 50);
    compared++;
    if (addr_err !== 1'b1) begin
      mismatched++;
      $display("FAIL addr_err_sticky: addr_err=%b required 1", addr_err);
    end
    check_count("addr_err_then_valid");
  endtask

  task automatic test_timeout();
    int hi = 1;
    int late = 0;
    do_reset();
    raise_req(4'd3, 4'd7);
    wait_ack(1'b1, 20, "timeout_ack_rise");
    while (aer_ack && hi < 400) begin @(negedge clk); if (aer_ack) hi++; end
    compared++;
    if (hi != 255 || timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_release: ack high %0d cycles timeout_err=%b required 255 1", hi, timeout_err);
    end
    aer_row = 4'd1; aer_col = 4'd1;
    repeat (30) begin @(negedge clk); if (aer_ack) late++; end
    compared++;
    if (late != 0) begin
      mismatched++;
      $display("FAIL timeout_ignore: ack high %0d cycles with req held, required 0", late);
    end
    check_count("timeout_ignore_count");
    aer_req = 1'b0;
    repeat (5) @(negedge clk);
    send_event(4'd2, 4'd4);
    check_count("timeout_next_event");
    compared++;
    if (timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
    end
    sender_done = 1'b1;
    consume(100, 50);
  endtask

  task automatic test_dis();
    int hi = 0;
    do_reset();
    aer_dis = 1'b1;
    raise_req(4'd6, 4'd2);
    repeat (20) begin @(negedge clk); if (aer_ack || ev_valid) hi++; end
    compared++;
    if (hi != 0) begin
      mismatched++;
      $display("FAIL dis_idle: ack/valid high %0d cycles while disabled, required 0", hi);
    end
    aer_dis = 1'b0;
    finish_handshake();
    check_count("dis_release_accept");
    raise_req(4'd8, 4'd11);
    repeat (3) @(negedge clk);
    aer_dis = 1'b1;
    finish_handshake();
    check_count("dis_during_settle");
    aer_dis = 1'b0;
    sender_done = 1'b1;
    consume(100, 50);
    raise_req(4'd4, 4'd4);
    wait_ack(1'b1, 20, "rst_ack_rise");
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (aer_ack !== 1'b0 || ev_valid !== 1'b0 || ev_count !== '0) begin
      mismatched++;
      $display("FAIL rst_in_ack: ack=%b valid=%b cnt=%0d required 0 0 0", aer_ack, ev_valid, ev_count);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    int pcts[3] = '{50, 15, 90};
    do_reset();
    foreach (pcts[p]) begin
      sender_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9) == 0)
              send_event(4'($urandom_range(15, 12)), 4'($urandom_range(15)));
            else
              send_event(4'($urandom_range(11)), 4'($urandom_range(11)));
          end
          sender_done = 1'b1;
        end
        consume(pcts[p], 20000);
      join
      check_count("stream_count");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_addr_err();
    test_timeout();
    test_dis();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
